led_breath_pwm: RTL and testbench

Breathing-LED PWM generator, directly downstream of the clock divider in the LED breath demo. It consumes the divider's divided-clock output as a tick stream, typically the 1 µs divider output. It produces a PWM LED drive whose duty ramps up, holds, ramps down and holds, continuously. Everything runs in the clk_int (12 MHz) domain. The divider output is treated as a synchronous level, not as a clock.

---
 rtl/led_breath_pwm.sv | 137 +++++++++++++
 tb/tb_led_breath_pwm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_breath_pwm.sv
// Breathing-LED PWM: a tick-driven PWM frame whose duty ramps up, holds, ramps down, holds.
// Optional hold states are compiled in with `define BREATH_HOLD_EN.
module led_breath_pwm #(
  parameter int unsigned PWM_PERIOD  = 1000,
  parameter int unsigned DUTY_STEP   = 2,
  parameter int unsigned HOLD_FRAMES = 100
) (
  input  logic        clk_int,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        enable,
  output logic        led,
  output logic [15:0] duty,
  output logic [1:0]  state,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_RISE    = 2'd0,
    ST_HOLD_HI = 2'd1,
    ST_FALL    = 2'd2,
    ST_HOLD_LO = 2'd3
  } state_e;

  localparam logic [15:0] PERIOD_M1 = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] PERIOD_16 = 16'(PWM_PERIOD);
  localparam logic [16:0] PERIOD_W  = 17'(PWM_PERIOD);
  localparam logic [15:0] STEP_16   = 16'(DUTY_STEP);
  localparam logic [16:0] STEP_W    = 17'(DUTY_STEP);

`ifdef BREATH_HOLD_EN
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  logic [HW-1:0] hcnt_q;
`endif

  logic        tick_d_q;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] duty_q;
  state_e      state_q;
  logic        led_q;
  logic        frame_done_q;
  logic        tick;
  logic        frame_end;
  logic [16:0] duty_w;
  logic [16:0] duty_up;

  // tick_in is a plain level; only its rising edge while enabled counts as a tick.
  assign tick      = tick_in & ~tick_d_q & enable;
  assign frame_end = tick & (pcnt_q == PERIOD_M1);
  assign duty_w    = {1'b0, duty_q};
  assign duty_up   = duty_w + STEP_W;

  always_comb begin
    pcnt_d = pcnt_q;
    if (tick) begin
      pcnt_d = frame_end ? 16'd0 : pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_int or negedge rst) begin
    if (!rst) begin
      tick_d_q     <= 1'b0;
      pcnt_q       <= '0;
      led_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tick_d_q     <= tick_in;
      pcnt_q       <= pcnt_d;
      led_q        <= (pcnt_q < duty_q) & enable;
      frame_done_q <= frame_end;
    end
  end

  // Duty and state only move at a frame end, so a frame never glitches.
  always_ff @(posedge clk_int or negedge rst) begin
    if (!rst) begin
      duty_q  <= '0;
      state_q <= ST_RISE;
`ifdef BREATH_HOLD_EN
      hcnt_q  <= '0;
`endif
    end else if (frame_end) begin
      case (state_q)
        ST_RISE: begin
          if (duty_up >= PERIOD_W) begin
            duty_q <= PERIOD_16;
`ifdef BREATH_HOLD_EN
            state_q <= ST_HOLD_HI;
`else
            state_q <= ST_FALL;
`endif
          end else begin
            duty_q <= duty_up[15:0];
          end
        end
        ST_FALL: begin
          if (duty_w <= STEP_W) begin
            duty_q <= '0;
`ifdef BREATH_HOLD_EN
            state_q <= ST_HOLD_LO;
`else
            state_q <= ST_RISE;
`endif
          end else begin
            duty_q <= duty_q - STEP_16;
          end
        end
`ifdef BREATH_HOLD_EN
        ST_HOLD_HI: begin
          if (hcnt_q == HOLD_LAST) begin
            hcnt_q  <= '0;
            state_q <= ST_FALL;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        ST_HOLD_LO: begin
          if (hcnt_q == HOLD_LAST) begin
            hcnt_q  <= '0;
            state_q <= ST_RISE;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= ST_RISE;
      endcase
    end
  end

  assign led        = led_q;
  assign duty       = duty_q;
  assign state      = state_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Bench for led_breath_pwm: two instances (step 5 and step 4) against a frame-indexed
// reference model of the breathing waveform, plus directed reset/pause/tick scenarios.
module tb_led_breath_pwm;

  localparam int P  = 10;
  localparam int S0 = 5;
  localparam int S1 = 4;
  localparam int HF = 2;
`ifdef BREATH_HOLD_EN
  localparam int HOLD_N = HF;
  localparam int N_D0 = 10;
  localparam int N_S0 = 9;
  localparam int N_D1 = 11;
  int lit_d0 [N_D0] = '{0, 5, 10, 10, 10, 5, 0, 0, 0, 5};
  int lit_s0 [N_S0] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int lit_d1 [N_D1] = '{0, 4, 8, 10, 10, 10, 6, 2, 0, 0, 0};
`else
  localparam int HOLD_N = 0;
  localparam int N_D0 = 6;
  localparam int N_S0 = 6;
  localparam int N_D1 = 7;
  int lit_d0 [N_D0] = '{0, 5, 10, 5, 0, 5};
  int lit_s0 [N_S0] = '{0, 0, 2, 2, 0, 0};
  int lit_d1 [N_D1] = '{0, 4, 8, 10, 6, 2, 0};
`endif

  logic        clk_int = 1'b0;
  logic        rst;
  logic        tick_in;
  logic        enable;
  logic        led0, led1, fd0, fd1;
  logic [15:0] duty0, duty1;
  logic [1:0]  st0, st1;

  led_breath_pwm #(.PWM_PERIOD(P), .DUTY_STEP(S0), .HOLD_FRAMES(HF)) u_dut (
    .clk_int(clk_int), .rst(rst), .tick_in(tick_in), .enable(enable),
    .led(led0), .duty(duty0), .state(st0), .frame_done(fd0)
  );

  led_breath_pwm #(.PWM_PERIOD(P), .DUTY_STEP(S1), .HOLD_FRAMES(HF)) u_sat (
    .clk_int(clk_int), .rst(rst), .tick_in(tick_in), .enable(enable),
    .led(led1), .duty(duty1), .state(st1), .frame_done(fd1)
  );

  // clock / reset
  always #5 clk_int = ~clk_int;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_pcnt [2];
  int   m_frame [2];
  logic m_prev;
  logic exp_led [2];
  logic exp_fd [2];
  int   hi_cnt [2];
  bit   clean [2];
  int   fd_seen [2];
  bit   toggle_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: the waveform is a function of the frame index
  function automatic int step_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int frame_duty(input int step, input int idx);
    int nr, len, k;
    nr  = (P + step - 1) / step;
    len = 2 * nr + 2 * HOLD_N;
    k   = idx % len;
    if (k < nr) return k * step;
    if (k < nr + HOLD_N) return P;
    if (k < 2 * nr + HOLD_N) return P - (k - nr - HOLD_N) * step;
    return 0;
  endfunction

  function automatic int frame_state(input int step, input int idx);
    int nr, len, k;
    nr  = (P + step - 1) / step;
    len = 2 * nr + 2 * HOLD_N;
    k   = idx % len;
    if (k < nr) return 0;
    if (k < nr + HOLD_N) return 1;
    if (k < 2 * nr + HOLD_N) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pcnt[i]  = 0;
      m_frame[i] = 0;
      exp_led[i] = 1'b0;
      exp_fd[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic t;
    if (!rst) begin
      model_reset();
    end else begin
      t = tick_in && !m_prev && enable;
      m_prev = tick_in;
      for (int i = 0; i < 2; i++) begin
        exp_led[i] = enable && (m_pcnt[i] < frame_duty(step_of(i), m_frame[i]));
        exp_fd[i]  = 1'b0;
        if (t) begin
          if (m_pcnt[i] == P - 1) begin
            m_pcnt[i] = 0;
            m_frame[i]++;
            exp_fd[i] = 1'b1;
          end else begin
            m_pcnt[i]++;
          end
        end
      end
    end
  endtask

  // per-frame bookkeeping: led high count and the literal duty/state sequences
  task automatic frame_book(input int i, input logic l, input logic [15:0] d, input logic [1:0] s);
    hi_cnt[i] += int'(l);
    if (exp_fd[i]) begin
      if (clean[i]) check(i == 0 ? "hi_cnt0" : "hi_cnt1", hi_cnt[i], 2 * frame_duty(step_of(i), m_frame[i] - 1));
      hi_cnt[i] = 0;
      clean[i]  = toggle_mode;
      fd_seen[i]++;
      if (i == 0) begin
        if (fd_seen[i] < N_D0) check("seq_duty0", d, lit_d0[fd_seen[i]]);
        if (fd_seen[i] < N_S0) check("seq_state0", s, lit_s0[fd_seen[i]]);
      end else begin
        if (fd_seen[i] < N_D1) check("seq_duty1", d, lit_d1[fd_seen[i]]);
      end
    end
  endtask

  task automatic compare_all();
    check("led0", led0, exp_led[0]);
    check("fd0", fd0, exp_fd[0]);
    check("duty0", duty0, frame_duty(S0, m_frame[0]));
    check("state0", st0, frame_state(S0, m_frame[0]));
    check("led1", led1, exp_led[1]);
    check("fd1", fd1, exp_fd[1]);
    check("duty1", duty1, frame_duty(S1, m_frame[1]));
    check("state1", st1, frame_state(S1, m_frame[1]));
    frame_book(0, led0, duty0, st0);
    frame_book(1, led1, duty1, st1);
  endtask

  // driver tasks
  task automatic cycle();
    if (!toggle_mode) begin
      clean[0] = 1'b0;
      clean[1] = 1'b0;
    end
    @(posedge clk_int);
    model_step();
    @(negedge clk_int);
    compare_all();
  endtask

  task automatic tog_cycles(input int n);
    toggle_mode = 1'b1;
    enable      = 1'b1;
    repeat (n) begin
      tick_in = ~tick_in;
      cycle();
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hi_cnt[i]  = 0;
      clean[i]   = toggle_mode;
      fd_seen[i] = 0;
    end
    cycle();
    check("start_duty0", duty0, lit_d0[0]);
    check("start_state0", st0, lit_s0[0]);
    check("start_duty1", duty1, lit_d1[0]);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("arst_led0", led0, 0);
    check("arst_duty0", duty0, 0);
    check("arst_state0", st0, 0);
    check("arst_fd0", fd0, 0);
    check("arst_led1", led1, 0);
    check("arst_duty1", duty1, 0);
    check("arst_fd1", fd1, 0);
    model_reset();
    repeat (3) cycle();
  endtask

  initial begin
    int guard;
    rst         = 1'b0;
    tick_in     = 1'b0;
    enable      = 1'b0;
    toggle_mode = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      hi_cnt[i] = 0; clean[i] = 1'b0; fd_seen[i] = 0;
    end
    repeat (3) cycle();
    check("rst_led0", led0, 0);
    check("rst_duty0", duty0, 0);
    check("rst_state0", st0, 0);
    check("rst_fd0", fd0, 0);

    // full breathing cycles with a tick every second clock
    toggle_mode = 1'b1;
    enable      = 1'b1;
    release_reset();
    tog_cycles(260);

    // pause mid-frame with tick_in held high
    toggle_mode = 1'b0;
    tick_in = 1'b0; cycle();
    tick_in = 1'b1; cycle();
    enable  = 1'b0;
    repeat (50) cycle();
    enable  = 1'b1;
    repeat (5) cycle();
    tog_cycles(100);

    // tick_in held high: exactly one advance
    toggle_mode = 1'b0;
    tick_in = 1'b0; cycle();
    tick_in = 1'b1;
    repeat (20) cycle();
    tick_in = 1'b0; cycle();
    tog_cycles(60);

    // randomized ticks and enable drops
    toggle_mode = 1'b0;
    repeat (3000) begin
      tick_in = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 15) != 0);
      cycle();
    end
    tog_cycles(60);

    // reset mid-frame once the step-4 instance sits at duty 6
    guard = 0;
    while (duty1 != 16'd6 && guard < 400) begin
      tick_in = ~tick_in;
      cycle();
      guard++;
    end
    check("wait_duty6", duty1, 6);
    tog_cycles(5);
    async_reset();
    release_reset();
    tog_cycles(260);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
